// File: rtl/stack_ctrl.sv
// Control stage for a LIFO cell array: turns push/pop requests into one-hot row
// selects and write strobes, and captures the shared read bus into dout.
module stack_ctrl #(
  parameter int N     = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [N-1:0]     i_din,
  output logic             o_ready,
  output logic [N-1:0]     o_dout,
  output logic             o_doutValid,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count,
  output logic             o_overflow,
  output logic             o_underflow,
  output logic [DEPTH-1:0] o_rowSel,
  output logic             o_writeEn,
  output logic [N-1:0]     o_cellIn,
  input  logic [N-1:0]     i_cellOut
);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  localparam logic [AW:0]      FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]      SP_ONE     = (AW+1)'(1);
  localparam logic [DEPTH-1:0] ROW_ONE    = DEPTH'(1);

  state_t           r_state;
  logic [AW:0]      r_sp;
  logic [N-1:0]     r_dout;
  logic             r_doutValid;
  logic             r_overflow;
  logic             r_underflow;
  logic [DEPTH-1:0] r_rowSel;
  logic             r_writeEn;
  logic [N-1:0]     r_cellIn;

  state_t           w_stateNext;
  logic [AW:0]      w_spNext;
  logic [AW:0]      w_spDec;
  logic [N-1:0]     w_doutNext;
  logic             w_doutValidNext;
  logic             w_overflowNext;
  logic             w_underflowNext;
  logic [DEPTH-1:0] w_rowSelNext;
  logic             w_writeEnNext;
  logic [N-1:0]     w_cellInNext;
  logic             w_full;
  logic             w_empty;

  // sp doubles as the occupancy count: the next free row is also the number of words held.
  assign w_full  = (r_sp == FULL_COUNT);
  assign w_empty = (r_sp == '0);
  assign w_spDec = r_sp - SP_ONE;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_sp        <= '0;
      r_dout      <= '0;
      r_doutValid <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_rowSel    <= '0;
      r_writeEn   <= 1'b0;
      r_cellIn    <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_sp        <= w_spNext;
      r_dout      <= w_doutNext;
      r_doutValid <= w_doutValidNext;
      r_overflow  <= w_overflowNext;
      r_underflow <= w_underflowNext;
      r_rowSel    <= w_rowSelNext;
      r_writeEn   <= w_writeEnNext;
      r_cellIn    <= w_cellInNext;
    end
  end

  // cell_in is only reloaded on an accepted push so the latch row keeps its input stable after WriteEn drops.
  always_comb begin
    w_stateNext     = r_state;
    w_spNext        = r_sp;
    w_doutNext      = r_dout;
    w_doutValidNext = 1'b0;
    w_overflowNext  = 1'b0;
    w_underflowNext = 1'b0;
    w_rowSelNext    = '0;
    w_writeEnNext   = 1'b0;
    w_cellInNext    = r_cellIn;
    case (r_state)
      IDLE: begin
        if (i_push && !w_full) begin
          w_cellInNext  = i_din;
          w_rowSelNext  = ROW_ONE << r_sp[AW-1:0];
          w_writeEnNext = 1'b1;
          w_stateNext   = WRITE;
        end else begin
          if (i_push && w_full) w_overflowNext = 1'b1;
          if (i_pop && !w_empty) begin
            w_rowSelNext = ROW_ONE << w_spDec[AW-1:0];
            w_stateNext  = READ;
          end else if (i_pop && w_empty) begin
            w_underflowNext = 1'b1;
          end
        end
      end
      WRITE: begin
        w_spNext    = r_sp + SP_ONE;
        w_stateNext = IDLE;
      end
      READ: begin
        w_doutNext      = i_cellOut;
        w_doutValidNext = 1'b1;
        w_spNext        = w_spDec;
        w_stateNext     = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  assign o_ready     = (r_state == IDLE);
  assign o_dout      = r_dout;
  assign o_doutValid = r_doutValid;
  assign o_full      = w_full;
  assign o_empty     = w_empty;
  assign o_count     = r_sp;
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;
  assign o_rowSel    = r_rowSel;
  assign o_writeEn   = r_writeEn;
  assign o_cellIn    = r_cellIn;

endmodule
